pio_instr_decoder: RTL and testbench
====================================

PIO_INSTR_DECODER -- requirements
Module: pio_instr_decoder

Interface
REQ-001 The block SHALL have these parameters: ADDR_W, default 10, boot-RAM word-address width; DATA_W, default 16, boot-RAM word width, fixed at two instruction bytes.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock, same 50 MHz domain as the HPS PIO slaves.
- reset_n  in  1  asynchronous, active-low reset.
- instruction  in  11  HPS-written PIO word: [10] toggle, [9:8] opcode, [7:0] data.
- boot_loader  in  1  HPS PIO flag; 1 = load mode.
- mem_addr  out  ADDR_W  boot-RAM write address.
- mem_wdata  out  DATA_W  boot-RAM write data.
- mem_we  out  1  single-cycle write strobe.
- run  out  1  core release, active high.
- busy  out  1  command in progress.
- error  out  1  sticky fault flag.
- ack_toggle  out  1  last executed toggle value, read back by HPS.

Function
REQ-003 The block SHALL register instruction and boot_loader once (instr_q, boot_q) before use; no other input path is permitted.
REQ-004 The FSM SHALL have states INIT, IDLE, EXEC, ACK.
- INIT: one cycle after reset release; tog_seen <= instr_q[10]; ack_toggle <= instr_q[10]; go to IDLE.
- IDLE: if instr_q[10] != tog_seen, capture opcode and data, set tog_seen <= instr_q[10], go to EXEC.
- EXEC: perform the opcode action (REQ-005..008); go to ACK.
- ACK: ack_toggle <= tog_seen; return to IDLE.
REQ-005 Opcode 00 CLR SHALL set addr = 0, lo_byte = 0, error = 0.
REQ-006 Opcode 01 LOAD_LO SHALL latch data into lo_byte; no write occurs.
REQ-007 Opcode 10 WRITE_HI SHALL, if boot_q = 1:
- drive mem_wdata = {data, lo_byte}, mem_addr = addr, mem_we = 1 for exactly the EXEC cycle;
- increment addr by 1 after the write, wrapping from 2^ADDR_W-1 to 0 and setting error on wrap.
If boot_q = 0, it SHALL suppress mem_we, leave addr unchanged, and set error.
REQ-008 Opcode 11 RUN SHALL set run = data[0] & ~boot_q.
REQ-009 Whenever boot_q = 1, run SHALL be 0 on the next cycle, overriding any other update.
REQ-010 Latency:
- instruction toggle change at edge N;
- instr_q updates at N+1; IDLE detects it; EXEC is N+2 (mem_we high);
- ACK is N+3; ack_toggle is updated after edge N+4.
REQ-011 busy SHALL be 1 in INIT, EXEC and ACK, and 0 in IDLE.
REQ-012 A toggle change during EXEC or ACK SHALL NOT be lost. IDLE compares levels, so the latest pending word is executed next; intermediate words written without waiting for ack are dropped (the HPS must poll ack_toggle).
REQ-013 Changes to data or opcode bits without a toggle change SHALL be ignored.
REQ-014 mem_addr SHALL always reflect addr; mem_wdata SHALL hold its last value when mem_we = 0.
REQ-015 error SHALL be sticky, cleared only by CLR or reset; CLR in the same EXEC as a wrap is impossible, since one opcode executes per EXEC.

Reset
REQ-016 While reset_n = 0 (asynchronous), the block SHALL hold: state = INIT, addr = 0, lo_byte = 0, mem_wdata = 0, mem_we = 0, run = 0, error = 0, ack_toggle = 0, tog_seen = 0, busy = 1.
REQ-017 Reset asserted mid-command SHALL abort it with no mem_we pulse. On release, INIT adopts the current toggle, so a stale toggle is not re-executed.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Reset release with instruction = 0x400 -> after INIT, ack_toggle = 1, no command executed, busy = 0.
- boot_loader = 1; CLR; LOAD_LO 0x34; WRITE_HI 0x12 (toggle alternating, ack awaited) -> one mem_we pulse, addr 0, wdata 0x1234, then mem_addr = 1, and each ack at N+4.
- boot_loader = 1, 1024 WRITE_HI commands -> last write at addr 1023, mem_addr wraps to 0, error = 1; CLR -> error = 0.
- boot_loader = 0, WRITE_HI -> no mem_we, addr unchanged, error = 1, ack still returned.
- RUN data = 0x01 with boot_loader = 0 -> run = 1; boot_loader raised -> run = 0 within 2 cycles; RUN with boot_loader = 1 -> run stays 0.
- Toggle flipped twice during EXEC (net unchanged) -> no further command; reset pulsed during EXEC -> mem_we = 0, all outputs at reset values.

Source files
------------

// File: rtl/pio_instr_decoder.sv
// HPS PIO instruction decoder: turns toggle-handshaked PIO words into
// boot-RAM writes, core release and status back to the HPS.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_INIT | one cycle after reset: adopt the current toggle as already seen
// S_IDLE | wait for the registered toggle to differ from the last one seen
// S_EXEC | perform the captured opcode (write strobe lives here)
// S_ACK  | publish the executed toggle on ack_toggle
module pio_instr_decoder #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [10:0]       instruction,
  input  logic              boot_loader,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              run,
  output logic              busy,
  output logic              error,
  output logic              ack_toggle
);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_EXEC, S_ACK} state_t;

  localparam logic [1:0] OP_CLR      = 2'b00;
  localparam logic [1:0] OP_LOAD_LO  = 2'b01;
  localparam logic [1:0] OP_WRITE_HI = 2'b10;
  localparam logic [1:0] OP_RUN      = 2'b11;

  state_t            r_state;
  state_t            w_next;
  logic [10:0]       r_instr_q;
  logic              r_boot_q;
  logic              r_tog_seen;
  logic [1:0]        r_op;
  logic [7:0]        r_data;
  logic [7:0]        r_lo;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_run;
  logic              r_error;
  logic              r_ack;
  logic              w_new_cmd;
  logic              w_we;
  logic [DATA_W-1:0] w_word;

  // Input capture stage; left unreset so it keeps tracking the PIO during
  // reset and INIT sees the live toggle right after release.
  always_ff @(posedge clk) begin
    r_instr_q <= instruction;
    r_boot_q  <= boot_loader;
  end

  assign w_new_cmd = (r_instr_q[10] != r_tog_seen);
  assign w_word    = DATA_W'({r_data, r_lo});

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_INIT;
    else          r_state <= w_next;
  end

  // Next-state, busy and write strobe decode.
  always_comb begin
    w_next = r_state;
    busy   = 1'b1;
    w_we   = 1'b0;
    case (r_state)
      S_INIT: w_next = S_IDLE;
      S_IDLE: begin
        busy = 1'b0;
        if (w_new_cmd) w_next = S_EXEC;
      end
      S_EXEC: begin
        w_we   = (r_op == OP_WRITE_HI) && r_boot_q;
        w_next = S_ACK;
      end
      S_ACK:  w_next = S_IDLE;
      default: w_next = S_INIT;
    endcase
  end

  // Command capture, opcode execution and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tog_seen <= 1'b0;
      r_op       <= OP_CLR;
      r_data     <= '0;
      r_lo       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_run      <= 1'b0;
      r_error    <= 1'b0;
      r_ack      <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_tog_seen <= r_instr_q[10];
          r_ack      <= r_instr_q[10];
        end
        S_IDLE: begin
          if (w_new_cmd) begin
            r_op       <= r_instr_q[9:8];
            r_data     <= r_instr_q[7:0];
            r_tog_seen <= r_instr_q[10];
          end
        end
        S_EXEC: begin
          case (r_op)
            OP_CLR: begin
              r_addr  <= '0;
              r_lo    <= '0;
              r_error <= 1'b0;
            end
            OP_LOAD_LO: r_lo <= r_data;
            OP_WRITE_HI: begin
              if (r_boot_q) begin
                r_wdata <= w_word;
                r_addr  <= r_addr + ADDR_W'(1);
                if (r_addr == {ADDR_W{1'b1}}) r_error <= 1'b1;
              end else begin
                r_error <= 1'b1;
              end
            end
            OP_RUN: r_run <= r_data[0] & ~r_boot_q;
            default: ;
          endcase
        end
        S_ACK: r_ack <= r_tog_seen;
        default: ;
      endcase
      // Load mode always holds the core, whatever the opcode did.
      if (r_boot_q) r_run <= 1'b0;
    end
  end

  assign mem_we     = w_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = w_we ? w_word : r_wdata;
  assign run        = r_run;
  assign error      = r_error;
  assign ack_toggle = r_ack;

endmodule

// File: tb/tb_pio_instr_decoder.sv
// Bench for pio_instr_decoder: directed scenarios followed by random
// command traffic, checked against a behavioural model of the command set.
module tb_pio_instr_decoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] instruction;
  logic        boot_loader;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        run;
  logic        busy;
  logic        error;
  logic        ack_toggle;

  pio_instr_decoder #(.ADDR_W(10), .DATA_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .instruction(instruction),
    .boot_loader(boot_loader), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .run(run), .busy(busy), .error(error),
    .ack_toggle(ack_toggle)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int we_total = 0;

  // model state
  logic        tog;
  int          m_addr;
  logic [7:0]  m_lo;
  logic        m_err;
  logic        m_run;
  logic        m_boot;
  logic [15:0] m_wdata;

  always @(negedge clk) if (mem_we === 1'b1) we_total++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_addr = 0; m_lo = 8'h00; m_err = 1'b0; m_run = 1'b0; m_wdata = 16'h0000;
  endtask

  task automatic set_boot(input logic b);
    boot_loader = b;
    tick(2);
    m_boot = b;
    if (b) m_run = 1'b0;
    chk("run_after_boot", run, m_run);
  endtask

  // Issue one command with a fresh toggle and wait for its acknowledge.
  task automatic send(input logic [1:0] op, input logic [7:0] d);
    int ack_k, we_k, nwe, ea;
    logic [9:0]  wa;
    logic [15:0] wd, ed;
    bit exp_we;
    tog = ~tog;
    instruction = {tog, op, d};
    exp_we = 1'b0; ea = 0; ed = '0;
    case (op)
      2'd0: begin m_addr = 0; m_lo = 8'h00; m_err = 1'b0; end
      2'd1: m_lo = d;
      2'd2: begin
        if (m_boot) begin
          exp_we = 1'b1; ea = m_addr; ed = {d, m_lo}; m_wdata = ed;
          if (m_addr == 1023) begin m_addr = 0; m_err = 1'b1; end
          else m_addr = m_addr + 1;
        end else m_err = 1'b1;
      end
      default: m_run = d[0] & ~m_boot;
    endcase
    if (m_boot) m_run = 1'b0;
    ack_k = 0; we_k = 0; nwe = 0; wa = '0; wd = '0;
    for (int k = 1; k <= 10 && ack_k == 0; k++) begin
      tick(1);
      if (mem_we === 1'b1) begin nwe++; we_k = k; wa = mem_addr; wd = mem_wdata; end
      if (ack_toggle === tog) ack_k = k;
    end
    chk("ack_latency", ack_k, 4);
    chk("busy_idle", busy, 1'b0);
    chk("we_count", nwe, exp_we ? 1 : 0);
    if (exp_we) begin
      chk("we_cycle", we_k, 2);
      chk("we_addr", wa, ea);
      chk("we_data", wd, ed);
    end
    chk("mem_addr", mem_addr, m_addr);
    chk("wdata_hold", mem_wdata, m_wdata);
    chk("error", error, m_err);
    chk("run", run, m_run);
  endtask

  // Data/opcode churn without a toggle change must do nothing.
  task automatic noise();
    int w0;
    w0 = we_total;
    instruction = {tog, 10'($urandom)};
    tick(5);
    chk("noise_we", we_total - w0, 0);
    chk("noise_ack", ack_toggle, tog);
    chk("noise_busy", busy, 1'b0);
    chk("noise_addr", mem_addr, m_addr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    int w0;
    reset_n = 1'b0; instruction = 11'h400; boot_loader = 1'b0;
    m_boot = 1'b0; tog = 1'b0; model_reset();
    tick(3);
    chk("rst_busy", busy, 1'b1);
    chk("rst_ack", ack_toggle, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_run", run, 1'b0);
    chk("rst_err", error, 1'b0);
    reset_n = 1'b1;
    w0 = we_total;
    tick(1);
    tog = 1'b1;
    chk("init_ack", ack_toggle, 1'b1);
    chk("init_busy", busy, 1'b0);
    tick(4);
    chk("init_no_cmd", we_total - w0, 0);
    chk("init_idle", busy, 1'b0);
    chk("init_addr", mem_addr, 0);

    // boot write sequence
    set_boot(1'b1);
    send(2'd0, 8'h00);
    send(2'd1, 8'h34);
    send(2'd2, 8'h12);

    // fill the whole RAM and wrap
    send(2'd0, 8'h00);
    for (int i = 0; i < 1024; i++) send(2'd2, 8'(i));
    chk("wrap_addr", mem_addr, 0);
    chk("wrap_err", error, 1'b1);
    send(2'd0, 8'h00);
    chk("clr_err", error, 1'b0);

    // write outside load mode
    set_boot(1'b0);
    send(2'd1, 8'h77);
    send(2'd2, 8'h55);
    chk("nonboot_err", error, 1'b1);

    // core release
    send(2'd3, 8'h01);
    chk("run_set", run, 1'b1);
    set_boot(1'b1);
    chk("run_cleared", run, 1'b0);
    send(2'd3, 8'h01);
    chk("run_in_boot", run, 1'b0);
    send(2'd0, 8'h00);

    // toggle flipped and restored while the command executes
    w0 = we_total;
    tog = ~tog;
    instruction = {tog, 2'b01, 8'hA5};
    m_lo = 8'hA5;
    tick(2);
    chk("exec_busy", busy, 1'b1);
    instruction[10] = ~tog;
    tick(1);
    instruction[10] = tog;
    tick(1);
    chk("flip_ack", ack_toggle, tog);
    tick(6);
    chk("flip_no_cmd", we_total - w0, 0);
    chk("flip_idle", busy, 1'b0);
    send(2'd2, 8'h5A);

    // reset in the middle of a write
    w0 = we_total;
    tog = ~tog;
    instruction = {tog, 2'b10, 8'hC3};
    tick(2);
    chk("pre_rst_we", mem_we, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("abort_we", mem_we, 1'b0);
    chk("abort_busy", busy, 1'b1);
    chk("abort_addr", mem_addr, 0);
    chk("abort_wdata", mem_wdata, 0);
    chk("abort_ack", ack_toggle, 1'b0);
    chk("abort_err", error, 1'b0);
    chk("abort_run", run, 1'b0);
    tick(2);
    chk("abort_no_pulse", we_total - w0, 0);
    reset_n = 1'b1;
    model_reset();
    tick(1);
    chk("rerelease_ack", ack_toggle, tog);
    tick(4);
    chk("rerelease_no_cmd", we_total - w0, 0);
    chk("rerelease_idle", busy, 1'b0);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) set_boot(1'($urandom));
      else if (r == 1) noise();
      else begin
        if ($urandom_range(0, 1) == 1) tick($urandom_range(1, 3));
        send(2'($urandom), 8'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
